// File: rtl/morse_round_controller.sv
// Game-round sequencer for the Morse trainer: fetches one ROM pattern per round,
// times the player's answer against a level-dependent window, keeps score.
module morse_round_controller #(
  parameter int ROUNDS       = 8,
  parameter int TICKS_EASY   = 40,
  parameter int TICKS_MEDIUM = 25,
  parameter int TICKS_HARD   = 15,
  parameter int SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               LoggedIn_easy,
  input  logic               LoggedIn_medium,
  input  logic               LoggedIn_hard,
  input  logic               start,
  input  logic               tick,
  output logic               rom_en,
  output logic [4:0]         rom_addr,
  input  logic [7:0]         rom_data,
  output logic [7:0]         pattern,
  output logic               pattern_valid,
  input  logic               ans_valid,
  input  logic               ans_correct,
  output logic [3:0]         round,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               game_over
);

  localparam int TMAX_EM = (TICKS_EASY > TICKS_MEDIUM) ? TICKS_EASY : TICKS_MEDIUM;
  localparam int TMAX    = (TMAX_EM > TICKS_HARD) ? TMAX_EM : TICKS_HARD;
  localparam int TIMER_W = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ANSWER,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]         level_q, level_d;
  logic [3:0]         round_q, round_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [7:0]         pattern_q, pattern_d;
  logic               pv_q, pv_d;
  logic               rom_en_q, rom_en_d;
  logic [4:0]         rom_addr_q, rom_addr_d;
  logic               busy_q, busy_d;
  logic               game_over_q, game_over_d;

  logic [1:0] sel_cnt;
  logic       level_ok;
  logic       logout;
  logic [1:0] sel_level;
  logic       start_ok;
  logic       timer_last;
  logic [3:0] round_inc;

  assign sel_cnt    = {1'b0, LoggedIn_easy} + {1'b0, LoggedIn_medium} + {1'b0, LoggedIn_hard};
  assign level_ok   = (sel_cnt == 2'd1);
  assign logout     = (sel_cnt == 2'd0);
  assign sel_level  = LoggedIn_hard ? 2'd2 : (LoggedIn_medium ? 2'd1 : 2'd0);
  assign start_ok   = start && level_ok;
  assign timer_last = (timer_q == TIMER_W'(1));
  assign round_inc  = round_q + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Logout outranks every other transition once a game is under way.
  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && logout) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start_ok) state_d = S_FETCH;
        S_FETCH:  state_d = S_WAIT;
        S_WAIT:   state_d = S_ANSWER;
        S_ANSWER: if (ans_valid || (tick && timer_last)) state_d = S_NEXT;
        S_NEXT:   state_d = (round_inc == 4'(ROUNDS)) ? S_DONE : S_FETCH;
        S_DONE:   if (start_ok) state_d = S_FETCH;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    level_d     = level_q;
    round_d     = round_q;
    score_d     = score_q;
    timer_d     = timer_q;
    pattern_d   = pattern_q;
    pv_d        = pv_q;
    rom_en_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    busy_d      = (state_d != S_IDLE);
    game_over_d = (state_d == S_DONE);

    if (state_q != S_IDLE && logout) begin
      pv_d    = 1'b0;
      score_d = '0;
      round_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            level_d = sel_level;
            round_d = '0;
            score_d = '0;
          end
        end
        S_WAIT: begin
          pattern_d = rom_data;
          pv_d      = 1'b1;
          case (level_q)
            2'd1:    timer_d = TIMER_W'(TICKS_MEDIUM);
            2'd2:    timer_d = TIMER_W'(TICKS_HARD);
            default: timer_d = TIMER_W'(TICKS_EASY);
          endcase
        end
        S_ANSWER: begin
          // An answer arriving with the expiring tick still counts.
          if (ans_valid) begin
            pv_d = 1'b0;
            if (ans_correct && score_q != {SCORE_W{1'b1}}) begin
              score_d = score_q + SCORE_W'(1);
            end
          end else if (tick) begin
            timer_d = timer_q - TIMER_W'(1);
            if (timer_last) pv_d = 1'b0;
          end
        end
        S_NEXT: begin
          pv_d    = 1'b0;
          round_d = round_inc;
        end
        default: ;
      endcase
    end

    if (state_d == S_FETCH) begin
      rom_en_d   = 1'b1;
      rom_addr_d = {level_d, round_d[2:0]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q     <= '0;
      round_q     <= '0;
      score_q     <= '0;
      timer_q     <= '0;
      pattern_q   <= '0;
      pv_q        <= 1'b0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      level_q     <= level_d;
      round_q     <= round_d;
      score_q     <= score_d;
      timer_q     <= timer_d;
      pattern_q   <= pattern_d;
      pv_q        <= pv_d;
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
    end
  end

  assign rom_en        = rom_en_q;
  assign rom_addr      = rom_addr_q;
  assign pattern       = pattern_q;
  assign pattern_valid = pv_q;
  assign round         = round_q;
  assign score         = score_q;
  assign busy          = busy_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_morse_round_controller.sv
// Bench for morse_round_controller: directed scenarios plus a randomized phase,
// all checked every cycle against a round/phase-age model of the game.
module tb_morse_round_controller;
  localparam int ROUNDS = 8;
  localparam int TE = 40, TM = 25, TH = 15;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic le = 1'b0, lm = 1'b0, lh = 1'b0;
  logic start = 1'b0, tick = 1'b0, ans_valid = 1'b0, ans_correct = 1'b0;
  logic [7:0] rom_data = 8'h00;
  logic rom_en, pattern_valid, busy, game_over;
  logic [4:0] rom_addr;
  logic [7:0] pattern;
  logic [3:0] round;
  logic [SW-1:0] score;

  morse_round_controller #(
    .ROUNDS(ROUNDS), .TICKS_EASY(TE), .TICKS_MEDIUM(TM), .TICKS_HARD(TH), .SCORE_W(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .LoggedIn_easy(le), .LoggedIn_medium(lm), .LoggedIn_hard(lh),
    .start(start), .tick(tick),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .pattern(pattern), .pattern_valid(pattern_valid),
    .ans_valid(ans_valid), .ans_correct(ans_correct),
    .round(round), .score(score), .busy(busy), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: game progress tracked as ages of fetch/close events.
  bit m_busy, m_pv, m_over, m_rom_en;
  int m_round, m_score, m_lvl, m_timer, m_pattern, m_addr;
  int fetch_age, close_age;

  bit rom_pend;
  logic [4:0] rom_pend_addr;
  int addr_log[$];

  function automatic logic [7:0] rom_fn(input logic [4:0] a);
    logic [7:0] x;
    x = {3'b000, a} * 8'd29 + 8'd71;
    return x ^ 8'hA5;
  endfunction

  function automatic int ticks_of(input int l);
    return (l == 2) ? TH : ((l == 1) ? TM : TE);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_pv = 0; m_over = 0; m_rom_en = 0;
    m_round = 0; m_score = 0; m_lvl = 0; m_timer = 0; m_pattern = 0; m_addr = 0;
    fetch_age = -1; close_age = -1;
  endtask

  task automatic issue_fetch();
    m_rom_en  = 1;
    m_addr    = m_lvl * 8 + m_round;
    fetch_age = 0;
  endtask

  task automatic model_step();
    int nsel;
    if (!rst) begin
      model_reset();
      return;
    end
    nsel = int'(le) + int'(lm) + int'(lh);
    if (m_busy && nsel == 0) begin
      m_busy = 0; m_pv = 0; m_over = 0; m_score = 0; m_round = 0; m_rom_en = 0;
      fetch_age = -1; close_age = -1;
      return;
    end
    m_rom_en = 0;
    if (fetch_age == 0) begin
      fetch_age = 1;
    end else if (fetch_age == 1) begin
      m_pattern = int'(rom_data);
      m_pv      = 1;
      m_timer   = ticks_of(m_lvl);
      fetch_age = -1;
    end else if (m_pv) begin
      if (ans_valid) begin
        if (ans_correct && m_score < (1 << SW) - 1) m_score++;
        m_pv = 0;
        close_age = 0;
      end else if (tick) begin
        m_timer--;
        if (m_timer == 0) begin
          m_pv = 0;
          close_age = 0;
        end
      end
    end else if (close_age == 0) begin
      close_age = -1;
      m_round++;
      if (m_round == ROUNDS) m_over = 1;
      else issue_fetch();
    end else if ((!m_busy || m_over) && start && nsel == 1) begin
      m_lvl   = lh ? 2 : (lm ? 1 : 0);
      m_round = 0;
      m_score = 0;
      m_over  = 0;
      m_busy  = 1;
      issue_fetch();
    end
  endtask

  task automatic check_all();
    chk("busy", busy, m_busy);
    chk("pattern_valid", pattern_valid, m_pv);
    chk("game_over", game_over, m_over);
    chk("round", round, m_round);
    chk("score", score, m_score);
    chk("rom_en", rom_en, m_rom_en);
    chk("rom_addr", rom_addr, m_addr);
    chk("pattern", pattern, m_pattern);
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge,
  // then the ROM answers the previous cycle's read and pulses are dropped.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    if (rom_en === 1'b1) addr_log.push_back(int'(rom_addr));
    rom_data      = rom_pend ? rom_fn(rom_pend_addr) : 8'($urandom);
    rom_pend      = (rom_en === 1'b1);
    rom_pend_addr = rom_addr;
    start     = 1'b0;
    ans_valid = 1'b0;
  endtask

  task automatic set_lvl(input int l);
    le = (l == 0);
    lm = (l == 1);
    lh = (l == 2);
  endtask

  task automatic wait_pv(input int maxc);
    for (int i = 0; i < maxc && !m_pv; i++) cycle();
    n_checks++;
    if (!m_pv) begin
      n_fail++;
      $display("FAIL wait_pv: pattern_valid not expected within %0d cycles", maxc);
    end
  endtask

  task automatic wait_over(input int maxc);
    for (int i = 0; i < maxc && !m_over; i++) cycle();
    n_checks++;
    if (!m_over) begin
      n_fail++;
      $display("FAIL wait_over: game_over not expected within %0d cycles", maxc);
    end
  endtask

  task automatic answer(input bit correct);
    ans_valid   = 1'b1;
    ans_correct = correct;
    cycle();
  endtask

  initial begin
    int cnt;
    int cur_lvl;
    int r;
    model_reset();
    rom_pend = 0;
    rom_pend_addr = '0;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_rom_en", rom_en, 0);
    chk("reset_pv", pattern_valid, 0);
    repeat (2) cycle();
    rst = 1'b1;
    cycle();

    // Reset in the middle of ANSWER.
    $display("scenario: reset mid-game");
    set_lvl(0);
    start = 1'b1;
    cycle();
    wait_pv(10);
    answer(1'b1);
    wait_pv(10);
    chk("pre_reset_score", score, 1);
    rst = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_pv", pattern_valid, 0);
    chk("async_score", score, 0);
    chk("async_round", round, 0);
    chk("async_game_over", game_over, 0);
    model_reset();
    cycle();
    rst = 1'b1;
    cycle();

    // Easy game, correct answer one cycle after each pattern_valid.
    $display("scenario: easy game, all correct");
    set_lvl(0);
    addr_log.delete();
    start = 1'b1;
    cycle();
    chk("lat_rom_en_c0", rom_en, 1);
    chk("lat_addr_c0", rom_addr, 0);
    chk("lat_pv_c0", pattern_valid, 0);
    cycle();
    chk("lat_rom_en_c1", rom_en, 0);
    chk("lat_pv_c1", pattern_valid, 0);
    cycle();
    chk("lat_pv_c2", pattern_valid, 1);
    chk("lat_pattern", pattern, rom_fn(5'd0));
    for (int k = 0; k < ROUNDS; k++) begin
      wait_pv(10);
      cycle();
      answer(1'b1);
    end
    wait_over(10);
    chk("easy_score", score, 8);
    chk("easy_round", round, 8);
    chk("easy_game_over", game_over, 1);
    chk("easy_fetches", addr_log.size(), 8);
    for (int k = 0; k < addr_log.size(); k++) chk("easy_addr", addr_log[k], k);

    // Hard game, ticking, never answered.
    $display("scenario: hard game, all timeouts");
    set_lvl(2);
    tick = 1'b1;
    addr_log.delete();
    start = 1'b1;
    cycle();
    for (int k = 0; k < ROUNDS; k++) begin
      wait_pv(10);
      cnt = 0;
      while (pattern_valid === 1'b1 && cnt < 100) begin
        cnt++;
        cycle();
      end
      chk("hard_pv_len", cnt, 15);
    end
    wait_over(10);
    chk("hard_score", score, 0);
    chk("hard_game_over", game_over, 1);
    chk("hard_fetches", addr_log.size(), 8);
    for (int k = 0; k < addr_log.size(); k++) chk("hard_addr", addr_log[k], 16 + k);
    tick = 1'b0;

    // Two level lines high: start must be ignored.
    $display("scenario: ambiguous level start");
    set_lvl(3);
    cycle();
    chk("logout_busy", busy, 0);
    le = 1'b1; lh = 1'b1; lm = 1'b0;
    start = 1'b1;
    cycle();
    for (int k = 0; k < 5; k++) begin
      chk("dual_busy", busy, 0);
      chk("dual_rom_en", rom_en, 0);
      cycle();
    end

    // Medium game: answer arrives with the expiring tick.
    $display("scenario: medium answer on expiring tick");
    set_lvl(1);
    start = 1'b1;
    cycle();
    wait_pv(10);
    tick = 1'b1;
    repeat (TM - 1) cycle();
    chk("med_pv_before_expiry", pattern_valid, 1);
    answer(1'b1);
    chk("med_score", score, 1);
    chk("med_pv_after", pattern_valid, 0);
    tick = 1'b0;

    // Logout during round 3, then a fresh medium start.
    $display("scenario: logout in round 3");
    wait_pv(10);
    answer(1'b1);
    wait_pv(10);
    chk("r3_round", round, 2);
    set_lvl(3);
    cycle();
    chk("lo_busy", busy, 0);
    chk("lo_score", score, 0);
    chk("lo_round", round, 0);
    chk("lo_pv", pattern_valid, 0);
    set_lvl(1);
    start = 1'b1;
    cycle();
    chk("restart_rom_en", rom_en, 1);
    chk("restart_addr", rom_addr, 8);

    // Randomized play against the model.
    $display("scenario: randomized play");
    cur_lvl = 1;
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 999);
      if (r < 3) set_lvl(3);
      else if (r < 8) begin
        le = 1'b1; lh = 1'b1; lm = 1'($urandom_range(0, 1));
      end else set_lvl(cur_lvl);
      if ($urandom_range(0, 99) < 2) cur_lvl = $urandom_range(0, 2);
      start       = ($urandom_range(0, 29) == 0);
      tick        = 1'($urandom_range(0, 1));
      ans_valid   = ($urandom_range(0, 6) == 0);
      ans_correct = 1'($urandom_range(0, 1));
      rst         = ($urandom_range(0, 1499) != 0);
      cycle();
    end
    rst = 1'b1;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_round_controller.md
# morse_round_controller

Game-round sequencer for the Morse trainer. After `difficulty_selector` asserts one of its `LoggedIn_*` level lines, this block runs a fixed number of rounds: it fetches each round's Morse pattern from the pattern ROM, presents it to the display/input logic, and times the player's answer against a difficulty-dependent limit. It also keeps the score and signals end of game.

## Interface

Parameters:
- `ROUNDS`, 8: rounds per game; legal range 1–8.
- `TICKS_EASY`, 40: answer window in `tick` pulses for easy.
- `TICKS_MEDIUM`, 25: answer window for medium.
- `TICKS_HARD`, 15: answer window for hard.
- `SCORE_W`, 4: score width.

Ports:
- `clk` in 1: the block's single clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `LoggedIn_easy`, `LoggedIn_medium`, `LoggedIn_hard` in 1 each: level selects from `difficulty_selector`.
- `start` in 1: new-game request, one-cycle pulse.
- `tick` in 1: timebase enable for the answer timer.
- `rom_en` out 1: ROM read enable.
- `rom_addr` out 5: ROM address, equal to level*8 + round index (easy 0, medium 1, hard 2).
- `rom_data` in 8: ROM data; valid one cycle after `rom_en`.
- `pattern` out 8: latched pattern for the current round.
- `pattern_valid` out 1: high while an answer is awaited.
- `ans_valid` in 1: player answer strobe.
- `ans_correct` in 1: qualifies `ans_valid`.
- `round` out 4: completed-round count.
- `score` out SCORE_W: correct answers, saturating.
- `busy` out 1: high when the block is not in IDLE.
- `game_over` out 1: high in DONE.

## Operation

- All outputs are registered. Async reset forces state IDLE and sets every output and internal counter to 0.
- Level is valid when exactly one `LoggedIn_*` is high. "Logged out" means all three are low.
- IDLE:
  - On `start` with a valid level: latch the level, clear `round` and `score`, go to FETCH.
  - On `start` with zero or more than one level line high: ignore it.
- FETCH: `rom_en`=1 and `rom_addr`={level, round[2:0]}. Go to WAIT.
- WAIT: capture `rom_data` into `pattern`. Load the timer with the TICKS_* value for the latched level. Set `pattern_valid`. Go to ANSWER.
- ANSWER:
  - On `ans_valid`: if `ans_correct`, increment `score` (saturating at all-ones). Go to NEXT.
  - Else on `tick`: decrement the timer. If the timer was 1, this is a timeout: go to NEXT with no score change.
  - If `ans_valid` and an expiring `tick` arrive in the same cycle, the answer wins.
  - `ans_valid` outside ANSWER is ignored.
- NEXT: clear `pattern_valid`, increment `round`. If the new `round`==ROUNDS, go to DONE; otherwise go to FETCH.
- DONE: `game_over`=1; `score` and `round` are held. A `start` with a valid level begins a new game exactly as from IDLE.
- Logout, in any state other than IDLE, takes priority over everything:
  - Next state is IDLE.
  - `pattern_valid`, `game_over`, `score` and `round` are cleared.
- Level changes after a game starts are ignored. Only the latched level is used, unless the change is a logout.

## Timing

- `start` sampled at edge 0 puts the block in FETCH, with `rom_en` high for cycle 0–1.
- `pattern` and `pattern_valid` update at edge 2. Latency from `start` to `pattern_valid` is therefore 2 cycles.
- `ans_valid` sampled at edge n:
  - `score` updates and `pattern_valid` falls at edge n.
  - `round` increments at edge n+1.
  - The next FETCH occupies cycle n+1 to n+2.
  - The next `pattern_valid` rises at edge n+3.
- Timeout: with `tick` high every cycle, `pattern_valid` stays high for exactly TICKS_x cycles.
- `game_over` rises on the edge after the final NEXT.
- Async reset mid-operation clears all outputs immediately, without waiting for a clock edge.

## Test plan

- Reset mid-game: assert `rst`=0 while in ANSWER → `busy`, `pattern_valid`, `score` and `round` are all 0 immediately; state is IDLE.
- Easy game, correct answer 1 cycle after each `pattern_valid` → `rom_addr` sequence 0..7, final `score`=8, `round`=8, `game_over`=1.
- Hard game, no answers, `tick` every cycle → each round's `pattern_valid` lasts 15 cycles, `rom_addr` 16..23, `score`=0, `game_over`=1.
- `start` with `LoggedIn_easy` and `LoggedIn_hard` both high → ignored; `busy` stays 0 and `rom_en` never asserts.
- Medium game: `ans_valid`=1, `ans_correct`=1 in the same cycle as the timer-expiring `tick` → `score` increments to 1.
- Logout (all `LoggedIn_*`=0) during round 3 → IDLE on the next edge; `busy`=0, `score`=0, `round`=0; a subsequent `start` with `LoggedIn_medium` fetches `rom_addr`=8.
